// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - action encoding and priority decode for the PC with return stack
package pc_pkg;

  typedef logic [2:0] action_t;

  localparam action_t ACT_HOLD = 3'd0;
  localparam action_t ACT_SET  = 3'd1;
  localparam action_t ACT_RET  = 3'd2;
  localparam action_t ACT_CALL = 3'd3;
  localparam action_t ACT_BR   = 3'd4;
  localparam action_t ACT_INC  = 3'd5;

  // Exactly one action per cycle; lower-priority requests are dropped.
  function automatic action_t decode_action(input logic stall,
                                            input logic set_pc,
                                            input logic ret,
                                            input logic call,
                                            input logic branch);
    action_t act;
    if (stall)       act = ACT_HOLD;
    else if (set_pc) act = ACT_SET;
    else if (ret)    act = ACT_RET;
    else if (call)   act = ACT_CALL;
    else if (branch) act = ACT_BR;
    else             act = ACT_INC;
    return act;
  endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// rtl/pc_ret_stack.sv - parametrised LIFO of return addresses
module pc_ret_stack #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          top_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] ONE = CW'(1);

  // Sized to the count range so every index is in bounds; unused rows trim away.
  logic [DATA_W-1:0] mem [0:(1<<CW)-1];

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign top_data = mem[count - ONE];
  assign err      = (push && full) || (pop && empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (pop && !empty) begin
      count <= count - ONE;
    end else if (push && !full) begin
      count <= count + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !pop) begin
      mem[count] <= push_data;
    end
  end

endmodule

// File: rtl/pc_stack.sv
// rtl/pc_stack.sv - N-bit PC with stall/branch/call/ret; sticky stack_err built only with PC_STACK_ERR_EN
module pc_stack
  import pc_pkg::*;
#(
  parameter int              PC_W        = 4,
  parameter int              STACK_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            set_pc,
  input  logic            branch,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] PC_INIT,
  input  logic [PC_W-1:0] BR_OFF,
  output logic [PC_W-1:0] PC_CURR,
  output logic            stack_full,
  output logic            stack_empty,
  output logic            stack_err
);

  action_t                          action;
  logic [PC_W-1:0]                  pc_next;
  logic [PC_W-1:0]                  pc_inc;
  logic [PC_W-1:0]                  stk_top;
  logic [$clog2(STACK_DEPTH+1)-1:0] stk_count;
  logic                             stk_push;
  logic                             stk_pop;
  logic                             stk_full;
  logic                             stk_empty;
  logic                             stk_err;

  assign pc_inc = PC_CURR + PC_W'(1);

  always_comb begin
    action   = decode_action(stall, set_pc, ret, call, branch);
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    pc_next  = PC_CURR;
    case (action)
      ACT_SET:  pc_next = PC_INIT;
      ACT_RET: begin
        // An empty pop falls back to a plain increment.
        stk_pop = 1'b1;
        pc_next = stk_empty ? pc_inc : stk_top;
      end
      ACT_CALL: begin
        stk_push = 1'b1;
        pc_next  = PC_INIT;
      end
      ACT_BR:   pc_next = PC_CURR + BR_OFF;
      ACT_INC:  pc_next = pc_inc;
      default:  pc_next = PC_CURR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) PC_CURR <= RESET_PC;
    else     PC_CURR <= pc_next;
  end

  pc_ret_stack #(
    .DATA_W (PC_W),
    .DEPTH  (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .count     (stk_count),
    .full      (stk_full),
    .empty     (stk_empty),
    .err       (stk_err)
  );

  assign stack_full  = stk_full;
  assign stack_empty = (stk_count == '0);

`ifdef PC_STACK_ERR_EN
  always_ff @(posedge clk) begin
    if (rst)          stack_err <= 1'b0;
    else if (stk_err) stack_err <= 1'b1;
  end
`else
  assign stack_err = stk_err & 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack.sv
// tb/tb_pc_stack.sv - directed self-checking bench for pc_stack
module tb_pc_stack;

`ifdef PC_STACK_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, stall, set_pc, branch, call, ret;
  logic [3:0] pc_init, br_off, pc_curr;
  logic       stack_full, stack_empty, stack_err;
  int         n_checks = 0;
  int         n_pass   = 0;

  always #5 clk = ~clk;

  pc_stack #(.PC_W(4), .STACK_DEPTH(4), .RESET_PC(4'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .set_pc      (set_pc),
    .branch      (branch),
    .call        (call),
    .ret         (ret),
    .PC_INIT     (pc_init),
    .BR_OFF      (br_off),
    .PC_CURR     (pc_curr),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic ctl(input logic s, input logic sp, input logic b,
                     input logic c, input logic r, input logic [3:0] init,
                     input logic [3:0] off);
    stall = s; set_pc = sp; branch = b; call = c; ret = r;
    pc_init = init; br_off = off;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    ctl(0, 0, 0, 0, 0, 4'h0, 4'h0);
    step();
    check("reset_pc", pc_curr, 4'h0);
    check("reset_empty", stack_empty, 1'b1);
    check("reset_full", stack_full, 1'b0);
    check("reset_err", stack_err, 1'b0);
    rst = 1'b0;

    // 20 idle cycles: 1..15, 0..4
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("inc_%0d", i), pc_curr, 32'(i % 16));
    end

    step();
    check("inc_to_5", pc_curr, 4'h5);
    ctl(0, 0, 1, 0, 0, 4'h0, 4'hE);
    step();
    check("branch_neg", pc_curr, 4'h3);
    ctl(0, 0, 1, 0, 0, 4'h0, 4'h2);
    step();
    check("branch_pos", pc_curr, 4'h5);

    ctl(0, 1, 0, 0, 0, 4'h2, 4'h0);
    step();
    check("set_pc_2", pc_curr, 4'h2);
    ctl(0, 0, 0, 1, 0, 4'h9, 4'h0);
    step();
    check("call_pc", pc_curr, 4'h9);
    check("call_nonempty", stack_empty, 1'b0);
    ctl(0, 0, 0, 0, 0, 4'h0, 4'h0);
    step();
    step();
    check("inc_11", pc_curr, 4'hB);
    ctl(0, 0, 0, 0, 1, 4'h0, 4'h0);
    step();
    check("ret_pc", pc_curr, 4'h3);
    check("ret_empty", stack_empty, 1'b1);

    // nested calls from 0, 4, 8, 12 push 1, 5, 9, 13
    ctl(0, 1, 0, 0, 0, 4'h0, 4'h0);
    step();
    ctl(0, 0, 0, 1, 0, 4'h4, 4'h0); step();
    ctl(0, 0, 0, 1, 0, 4'h8, 4'h0); step();
    ctl(0, 0, 0, 1, 0, 4'hC, 4'h0); step();
    check("nest3_full", stack_full, 1'b0);
    ctl(0, 0, 0, 1, 0, 4'h2, 4'h0); step();
    check("nest4_pc", pc_curr, 4'h2);
    check("nest4_full", stack_full, 1'b1);
    check("nest4_err", stack_err, 1'b0);
    ctl(0, 0, 0, 1, 0, 4'h7, 4'h0); step();
    check("overflow_pc", pc_curr, 4'h7);
    check("overflow_err", stack_err, ERR_EXP);
    check("overflow_full", stack_full, 1'b1);
    ctl(0, 0, 0, 0, 1, 4'h0, 4'h0);
    step(); check("pop1", pc_curr, 4'hD);
    check("pop1_notfull", stack_full, 1'b0);
    step(); check("pop2", pc_curr, 4'h9);
    step(); check("pop3", pc_curr, 4'h5);
    step(); check("pop4", pc_curr, 4'h1);
    check("pop4_empty", stack_empty, 1'b1);

    // underflow from a clean state
    rst = 1'b1;
    ctl(0, 0, 0, 0, 0, 4'h0, 4'h0);
    step();
    rst = 1'b0;
    check("rst2_err", stack_err, 1'b0);
    ctl(0, 1, 0, 0, 0, 4'h6, 4'h0); step();
    ctl(0, 0, 0, 0, 1, 4'h0, 4'h0); step();
    check("underflow_pc", pc_curr, 4'h7);
    check("underflow_err", stack_err, ERR_EXP);
    check("underflow_empty", stack_empty, 1'b1);

    // call+ret together with one entry holding 4
    ctl(0, 1, 0, 0, 0, 4'h3, 4'h0); step();
    ctl(0, 0, 0, 1, 0, 4'h9, 4'h0); step();
    check("call9", pc_curr, 4'h9);
    ctl(0, 0, 0, 1, 1, 4'hC, 4'h0); step();
    check("callret_pc", pc_curr, 4'h4);
    check("callret_empty", stack_empty, 1'b1);
    ctl(0, 0, 0, 1, 0, 4'h8, 4'h0); step();
    check("call8", pc_curr, 4'h8);
    ctl(1, 1, 0, 1, 1, 4'h1, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_pc_%0d", i), pc_curr, 4'h8);
    end
    check("stall_nonempty", stack_empty, 1'b0);
    check("stall_err", stack_err, ERR_EXP);
    ctl(0, 0, 0, 0, 1, 4'h0, 4'h0); step();
    check("post_stall_ret", pc_curr, 4'h5);

    ctl(0, 0, 0, 1, 0, 4'h8, 4'h0); step();
    ctl(1, 1, 0, 1, 0, 4'h1, 4'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_stall_pc", pc_curr, 4'h0);
    check("rst_stall_empty", stack_empty, 1'b1);
    check("rst_stall_err", stack_err, 1'b0);
    ctl(0, 0, 0, 0, 1, 4'h0, 4'h0); step();
    check("rst_cleared_ret", pc_curr, 4'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter with a hardware return-address stack.
- Generalises the fixed 4-bit increment/load PC to N bits, adding stall, signed relative branch, call and return.
- Sits at the front of the fetch path; PC_CURR drives the instruction memory address.
- All state is registered on clk; every control input takes effect on the next rising edge.

Parameters:
- PC_W, 4, PC and address width in bits (≥2).
- STACK_DEPTH, 4, number of return-address entries (≥1, power of 2 not required).
- RESET_PC, 0, PC value loaded on reset (PC_W bits).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and stack; all other controls ignored.
- set_pc  in  1  absolute jump to PC_INIT.
- branch  in  1  relative jump: PC_CURR + BR_OFF.
- call  in  1  push PC_CURR+1, then jump to PC_INIT.
- ret  in  1  pop top of stack into PC.
- PC_INIT  in  PC_W  absolute target for set_pc and call.
- BR_OFF  in  PC_W  two's-complement branch offset.
- PC_CURR  out  PC_W  current PC (registered).
- stack_full  out  1  stack count == STACK_DEPTH.
- stack_empty  out  1  stack count == 0.
- stack_err  out  1  sticky overflow/underflow flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at an edge): PC_CURR=RESET_PC, stack count=0, stack_empty=1, stack_full=0, stack_err=0. Reset overrides every other input, including mid-call or mid-stall.
- Priority at each edge: rst > stall > set_pc > ret > call > branch > increment. Exactly one action per cycle; lower-priority requests in the same cycle are dropped, not queued.
- Increment (no control asserted): PC_CURR <= PC_CURR+1 mod 2^PC_W. All-ones wraps to 0.
- Branch: PC_CURR <= (PC_CURR + BR_OFF) mod 2^PC_W. BR_OFF is sign-extended implicitly by the modular sum, so BR_OFF = all-ones means PC-1.
- set_pc: PC_CURR <= PC_INIT. Stack untouched.
- Call with stack not full: push (PC_CURR+1 mod 2^PC_W), count+1, PC_CURR <= PC_INIT.
- Call with stack full: the jump still occurs, the push is discarded, count is unchanged, stack_err is set.
- Ret with stack not empty: PC_CURR <= top entry, count-1.
- Ret with stack empty: treated as an increment (PC+1), stack_err is set.
- call and ret asserted together: ret wins and call is ignored, per priority.
- Stall: PC, stack contents, count and stack_err all hold.
- Latency: 1 cycle from control sample to new PC_CURR. Flags reflect the post-edge count in the same cycle as PC_CURR.
- stack_full and stack_empty are registered or derived from the registered count only; there is no combinational path from inputs.
- stack_err clears only on rst.

Optional Feature:
- Macro: PC_STACK_ERR_EN.
- Defined: stack_err behaves as above (sticky, set on overflow or underflow).
- Undefined: stack_err is tied to 0 and its register is not built. Overflow and underflow handling of PC and stack is otherwise identical (jump without push; increment on empty ret).

Decomposition:
- Package pc_pkg:
  - action encoding localparams for ACT_HOLD, ACT_SET, ACT_RET, ACT_CALL, ACT_BR, ACT_INC;
  - a priority-decode function returning the action from the control bits.
- One sub-module, pc_ret_stack:
  - parametrised LIFO with push, pop, data in/out, count, full and empty;
  - synchronous reset clears the count only;
  - push when full and pop when empty are no-ops with an error pulse output.
- pc_stack instantiates pc_ret_stack and contains the next-PC mux and the PC register.

Test Plan:
- Reset then 20 idle cycles, PC_W=4, RESET_PC=0 → PC_CURR sequence 0,1,…,15,0,1,2,3,4 (wrap verified).
- PC=5, branch=1, BR_OFF=4'hE → next PC=3. Then BR_OFF=4'h2 → PC=5.
- PC=2, call=1, PC_INIT=9 → PC=9, stack_empty=0. Increment to 11, then ret=1 → PC=3, stack_empty=1.
- Four nested calls from PC 0,4,8,12 (STACK_DEPTH=4) → stack_full=1, stack_err=0. A fifth call to 7 → PC=7, stack_err=1. Four rets → PCs 13,9,5,1, stack_empty=1.
- ret on empty stack at PC=6 → PC=7, stack_err=1 (0 with PC_STACK_ERR_EN undefined).
- call and ret together with depth 1 and top=4 → PC=4, push ignored. Then stall=1 with set_pc=1 for 3 cycles → PC holds. Then rst=1 during stall → PC=RESET_PC, count=0, stack_err=0.
